// File: rtl/nano_io_pkg.sv
// Shared definitions for Nano CPU I/O peripherals.
// Holds the nano_timer register offsets, CTRL bit positions and the STATUS TF position.
// The block base address is deliberately not here; each instance sets its own.
package nano_io_pkg;

  // Register offsets within an 8-byte I/O window (add[2:0])
  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_PRESC  = 3'd1;
  localparam logic [2:0] TMR_RLD_L  = 3'd2;
  localparam logic [2:0] TMR_RLD_H  = 3'd3;
  localparam logic [2:0] TMR_SNAP_L = 3'd4;
  localparam logic [2:0] TMR_SNAP_H = 3'd5;
  localparam logic [2:0] TMR_STATUS = 3'd6;

  // CTRL bit positions
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_CAP    = 3;

  // STATUS bit positions
  localparam int unsigned STATUS_TF = 0;

  // Stored CTRL state; CAP is a strobe and is not kept
  typedef struct packed {
    logic irq_en;
    logic auto_rld;
    logic en;
  } tmr_ctrl_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler for nano_timer: emits a one-cycle tick every presc+1 cycles while enabled.
// Ports:
//   CLK   - system clock
//   NRST  - synchronous active-low reset
//   en    - run; pcnt is held at 0 while low
//   presc - terminal prescaler value (period = presc+1)
//   tick  - high in the cycle where pcnt equals presc
module tick_prescaler (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       en,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] pcnt_q;
  logic [7:0] pcnt_d;

  // Equality compare: if presc drops below pcnt, pcnt runs on and wraps at 8'hFF.
  assign tick = en & (pcnt_q == presc);

  always_comb begin
    pcnt_d = pcnt_q + 8'd1;
    if (!en || tick) begin
      pcnt_d = 8'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      pcnt_q <= 8'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/nano_timer.sv
// nano_timer: memory-mapped 16-bit down-counting timer on the Nano CPU I/O bus.
// Ports:
//   CLK     - system clock
//   NRST    - synchronous active-low reset
//   add     - I/O address (io_add); block decodes add[7:3] == BASE_ADD[7:3]
//   data_i  - write data (io_o)
//   we      - write strobe, sampled on the rising edge
//   data_o  - read data (io_i), combinational from add
//   TMR_IRQ - interrupt level, TF & IRQ_EN
module nano_timer
  import nano_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADD = 8'h10
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic [7:0] add,
  input  logic [7:0] data_i,
  input  logic       we,
  output logic [7:0] data_o,
  output logic       TMR_IRQ
);

  tmr_ctrl_t   ctrl_q, ctrl_d;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] rld_q, rld_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tf_q, tf_d;

  logic       sel;
  logic [2:0] off;
  logic       tick;
  logic       expire;
  logic       wr_ctrl, wr_presc, wr_rld_l, wr_rld_h, wr_status;

  assign sel = (add[7:3] == BASE_ADD[7:3]);
  assign off = add[2:0];

  assign wr_ctrl   = we & sel & (off == TMR_CTRL);
  assign wr_presc  = we & sel & (off == TMR_PRESC);
  assign wr_rld_l  = we & sel & (off == TMR_RLD_L);
  assign wr_rld_h  = we & sel & (off == TMR_RLD_H);
  assign wr_status = we & sel & (off == TMR_STATUS);

  tick_prescaler u_presc (
    .CLK   (CLK),
    .NRST  (NRST),
    .en    (ctrl_q.en),
    .presc (presc_q),
    .tick  (tick)
  );

  assign expire  = tick & (cnt_q == 16'd0);
  assign TMR_IRQ = tf_q & ctrl_q.irq_en;

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    rld_d   = rld_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    tf_d    = tf_q;

    if (tick) begin
      if (cnt_q != 16'd0) begin
        cnt_d = cnt_q - 16'd1;
      end else if (ctrl_q.auto_rld) begin
        cnt_d = rld_q;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end

    if (wr_presc) presc_d       = data_i;
    if (wr_rld_l) rld_d[7:0]    = data_i;
    if (wr_rld_h) rld_d[15:8]   = data_i;

    // A CTRL write overrides the one-shot auto-clear of EN in the same cycle.
    if (wr_ctrl) begin
      ctrl_d.en       = data_i[CTRL_EN];
      ctrl_d.auto_rld = data_i[CTRL_AUTO];
      ctrl_d.irq_en   = data_i[CTRL_IRQ_EN];
      // Reload only on a 0->1 transition; tick needs EN=1 so this never collides with it.
      if (!ctrl_q.en && data_i[CTRL_EN]) begin
        cnt_d = rld_q;
      end
      // Snapshot takes the pre-edge count.
      if (data_i[CTRL_CAP]) begin
        snap_d = cnt_q;
      end
    end

    // Hardware set beats a software clear in the same cycle.
    if (wr_status && data_i[STATUS_TF]) tf_d = 1'b0;
    if (expire)                          tf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      ctrl_q  <= '0;
      presc_q <= 8'd0;
      rld_q   <= 16'd0;
      snap_q  <= 16'd0;
      cnt_q   <= 16'd0;
      tf_q    <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      rld_q   <= rld_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      tf_q    <= tf_d;
    end
  end

  always_comb begin
    data_o = 8'h00;
    if (sel) begin
      case (off)
        TMR_CTRL:   data_o = {5'b0, ctrl_q.irq_en, ctrl_q.auto_rld, ctrl_q.en};
        TMR_PRESC:  data_o = presc_q;
        TMR_RLD_L:  data_o = rld_q[7:0];
        TMR_RLD_H:  data_o = rld_q[15:8];
        TMR_SNAP_L: data_o = snap_q[7:0];
        TMR_SNAP_H: data_o = snap_q[15:8];
        TMR_STATUS: data_o = {7'b0, tf_q};
        default:    data_o = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_nano_timer.sv
// Directed self-checking bench for nano_timer (BASE_ADD = 8'h10).
module tb_nano_timer;

  logic       CLK = 1'b0;
  logic       NRST = 1'b0;
  logic [7:0] add = 8'h00;
  logic [7:0] data_i = 8'h00;
  logic       we = 1'b0;
  logic [7:0] data_o;
  logic       TMR_IRQ;

  int nvec = 0;
  int nerr = 0;

  nano_timer #(.BASE_ADD(8'h10)) dut (
    .CLK     (CLK),
    .NRST    (NRST),
    .add     (add),
    .data_i  (data_i),
    .we      (we),
    .data_o  (data_o),
    .TMR_IRQ (TMR_IRQ)
  );

  always #10 CLK = ~CLK;

  // Write lands on the next rising edge; returns 1ns after that edge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    add = a;
    data_i = d;
    we = 1'b1;
    @(posedge CLK);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    add = a;
    #1;
    d = data_o;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    NRST = 1'b0;
    @(posedge CLK);
    #1;
    NRST = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rd(8'h10 + 8'(i), d);
      nvec++;
      if (d !== 8'h00) begin
        $display("FAIL reset_reg%0d: got %h want 00", i, d);
        nerr++;
      end
    end
    nvec++;
    if (TMR_IRQ !== 1'b0) begin
      $display("FAIL reset_irq: got %b want 0", TMR_IRQ);
      nerr++;
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] d;
    do_reset();
    wr(8'h11, 8'h03);
    wr(8'h12, 8'h04);
    wr(8'h13, 8'h00);
    wr(8'h10, 8'h05);                       // edge k
    repeat (19) @(posedge CLK);
    #1;
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h00 || TMR_IRQ !== 1'b0) begin
      $display("FAIL oneshot_early: tf=%h irq=%b want 00/0 at k+19", d, TMR_IRQ);
      nerr++;
    end
    @(posedge CLK);
    #1;
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h01 || TMR_IRQ !== 1'b1) begin
      $display("FAIL oneshot_expire: tf=%h irq=%b want 01/1 at k+20", d, TMR_IRQ);
      nerr++;
    end
    rd(8'h10, d);
    nvec++;
    if (d !== 8'h04) begin
      $display("FAIL oneshot_ctrl: got %h want 04", d);
      nerr++;
    end
    repeat (10) @(posedge CLK);
    #1;
    nvec++;
    if (TMR_IRQ !== 1'b1) begin
      $display("FAIL oneshot_irq_hold: got %b want 1", TMR_IRQ);
      nerr++;
    end
    wr(8'h10, 8'h0C);                       // CAP with IRQ_EN kept
    rd(8'h14, d);
    nvec++;
    if (d !== 8'h00) begin
      $display("FAIL oneshot_snap_l: got %h want 00", d);
      nerr++;
    end
    rd(8'h10, d);
    nvec++;
    if (d !== 8'h04) begin
      $display("FAIL oneshot_cap_reads0: got %h want 04", d);
      nerr++;
    end
    wr(8'h16, 8'h01);
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h00 || TMR_IRQ !== 1'b0) begin
      $display("FAIL oneshot_clear: tf=%h irq=%b want 00/0", d, TMR_IRQ);
      nerr++;
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] d;
    do_reset();
    wr(8'h11, 8'h00);
    wr(8'h12, 8'h02);
    wr(8'h10, 8'h07);                       // edge k
    @(posedge CLK);                         // k+1
    @(posedge CLK);                         // k+2
    #1;
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h00) begin
      $display("FAIL auto_early: tf=%h want 00 at k+2", d);
      nerr++;
    end
    @(posedge CLK);                         // k+3
    #1;
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h01 || TMR_IRQ !== 1'b1) begin
      $display("FAIL auto_first: tf=%h irq=%b want 01/1 at k+3", d, TMR_IRQ);
      nerr++;
    end
    wr(8'h16, 8'h01);                       // k+4
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h00) begin
      $display("FAIL auto_w1c: tf=%h want 00 at k+4", d);
      nerr++;
    end
    @(posedge CLK);                         // k+5
    #1;
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h00) begin
      $display("FAIL auto_mid: tf=%h want 00 at k+5", d);
      nerr++;
    end
    @(posedge CLK);                         // k+6
    #1;
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h01) begin
      $display("FAIL auto_second: tf=%h want 01 at k+6", d);
      nerr++;
    end
    // Collision: clear at k+7, then W1C on the terminal tick at k+9
    wr(8'h16, 8'h01);                       // k+7
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h00 || TMR_IRQ !== 1'b0) begin
      $display("FAIL coll_pre: tf=%h irq=%b want 00/0 at k+7", d, TMR_IRQ);
      nerr++;
    end
    @(posedge CLK);                         // k+8
    wr(8'h16, 8'h01);                       // k+9
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h01 || TMR_IRQ !== 1'b1) begin
      $display("FAIL coll_set_wins: tf=%h irq=%b want 01/1 at k+9", d, TMR_IRQ);
      nerr++;
    end
    wr(8'h10, 8'h00);
  endtask

  task automatic test_snapshot();
    logic [7:0] d;
    do_reset();
    wr(8'h12, 8'h34);
    wr(8'h13, 8'h12);
    wr(8'h11, 8'h00);
    wr(8'h10, 8'h01);                       // edge k, cnt=1234
    repeat (4) @(posedge CLK);              // k+1..k+4, cnt=1230 after k+4
    wr(8'h10, 8'h09);                       // CAP at k+5
    rd(8'h14, d);
    nvec++;
    if (d !== 8'h30) begin
      $display("FAIL snap_l: got %h want 30", d);
      nerr++;
    end
    rd(8'h15, d);
    nvec++;
    if (d !== 8'h12) begin
      $display("FAIL snap_h: got %h want 12", d);
      nerr++;
    end
    rd(8'h10, d);
    nvec++;
    if (d !== 8'h01) begin
      $display("FAIL snap_ctrl: got %h want 01", d);
      nerr++;
    end
    repeat (7) @(posedge CLK);
    #1;
    rd(8'h14, d);
    nvec++;
    if (d !== 8'h30) begin
      $display("FAIL snap_hold: got %h want 30", d);
      nerr++;
    end
    wr(8'h10, 8'h00);
  endtask

  task automatic test_decode();
    logic [7:0] d;
    do_reset();
    wr(8'h18, 8'hFF);
    wr(8'h14, 8'hFF);
    wr(8'h17, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      rd(8'h10 + 8'(i), d);
      nvec++;
      if (d !== 8'h00) begin
        $display("FAIL decode_reg%0d: got %h want 00", i, d);
        nerr++;
      end
    end
    rd(8'h18, d);
    nvec++;
    if (d !== 8'h00) begin
      $display("FAIL decode_unsel: got %h want 00", d);
      nerr++;
    end
    wr(8'h11, 8'hA5);
    wr(8'h13, 8'h5A);
    rd(8'h11, d);
    nvec++;
    if (d !== 8'hA5) begin
      $display("FAIL rw_presc: got %h want a5", d);
      nerr++;
    end
    rd(8'h13, d);
    nvec++;
    if (d !== 8'h5A) begin
      $display("FAIL rw_rld_h: got %h want 5a", d);
      nerr++;
    end
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] d;
    do_reset();
    wr(8'h11, 8'h00);
    wr(8'h12, 8'h03);
    wr(8'h10, 8'h05);                       // edge k
    @(posedge CLK);
    do_reset();                             // NRST low at k+2
    for (int i = 0; i < 8; i++) begin
      rd(8'h10 + 8'(i), d);
      nvec++;
      if (d !== 8'h00) begin
        $display("FAIL midreset_reg%0d: got %h want 00", i, d);
        nerr++;
      end
    end
    repeat (10) @(posedge CLK);
    #1;
    rd(8'h16, d);
    nvec++;
    if (d !== 8'h00 || TMR_IRQ !== 1'b0) begin
      $display("FAIL midreset_noirq: tf=%h irq=%b want 00/0", d, TMR_IRQ);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_snapshot();
    test_decode();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
